rr_arbiter8: RTL and testbench

//   Round-robin arbiter sharing one resource among N requesters. Produces a
//   one-hot grant and its 3-bit encoded index. Holds the grant until the

---
 rtl/rr_arbiter8_pkg.sv | 17 +
 rtl/rr_arbiter8_pick.sv | 29 ++
 rtl/rr_arbiter8.sv | 113 +++++++++++
 tb/tb_rr_arbiter8.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes, hold limit
// and FSM state encoding.
package rr_arbiter8_pkg;

   localparam int ARB_N    = 8;
   localparam int ARB_IDW  = 3;
   localparam int MAX_HOLD = 16;
   localparam int HCW      = $clog2(MAX_HOLD);

   localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

endpackage

// File: rtl/rr_arbiter8_pick.sv
// Combinational round-robin picker: rotate the request vector so ptr sits at
// bit 0, take the lowest set bit, then add ptr back to get the real index.
module rr_arbiter8_pick
   import rr_arbiter8_pkg::*;
(
   input  logic [ARB_N-1:0]   req_i,
   input  logic [ARB_IDW-1:0] ptr_i,
   output logic [ARB_IDW-1:0] pick_id_o,
   output logic               any_req_o
);

   logic [2*ARB_N-1:0] dbl;
   logic [ARB_N-1:0]   rot;
   logic [ARB_IDW-1:0] enc;

   always_comb begin
      dbl = {req_i, req_i} >> ptr_i;
      rot = dbl[ARB_N-1:0];
      enc = '0;
      // Scan downwards so the lowest set bit is the last one written.
      for (int i = ARB_N - 1; i >= 0; i--) begin
         if (rot[i]) enc = i[ARB_IDW-1:0];
      end
   end

   assign pick_id_o = enc + ptr_i;
   assign any_req_o = |req_i;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with one-hot and encoded grant,
// release on done / request drop, and forced release after MAX_HOLD cycles.
module rr_arbiter8
   import rr_arbiter8_pkg::*;
(
   input  logic               clk,
   input  logic               resetn,
   input  logic [ARB_N-1:0]   req,
   input  logic               done,
   output logic [ARB_N-1:0]   grant,
   output logic [ARB_IDW-1:0] grant_id,
   output logic               grant_valid,
   output logic               timeout_err,
   output logic               dbg_state_o,
   output logic [ARB_IDW-1:0] dbg_ptr_o
);

   state_e             state_q, state_d;
   logic [ARB_IDW-1:0] ptr_q, ptr_d;
   logic [HCW-1:0]     hold_q, hold_d;
   logic [ARB_N-1:0]   grant_q, grant_d;
   logic [ARB_IDW-1:0] gid_q, gid_d;
   logic               valid_q, valid_d;
   logic               tmo_q, tmo_d;

   logic [ARB_IDW-1:0] pick_id;
   logic               any_req;
   logic               release_w;
   logic               timeout_w;

   rr_arbiter8_pick u_pick (
      .req_i     (req),
      .ptr_i     (ptr_q),
      .pick_id_o (pick_id),
      .any_req_o (any_req)
   );

   // A normal release (done or request drop) takes precedence over timeout.
   assign release_w = done | ~req[gid_q];
   assign timeout_w = (hold_q == HOLD_LAST);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         hold_q  <= '0;
         grant_q <= '0;
         gid_q   <= '0;
         valid_q <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         grant_q <= grant_d;
         gid_q   <= gid_d;
         valid_q <= valid_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (any_req) state_d = ST_BUSY;
         ST_BUSY: if (release_w || timeout_w) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      grant_d = grant_q;
      gid_d   = gid_q;
      valid_d = valid_q;
      tmo_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               grant_d          = '0;
               grant_d[pick_id] = 1'b1;
               gid_d            = pick_id;
               valid_d          = 1'b1;
               hold_d           = '0;
            end
         end
         ST_BUSY: begin
            if (release_w || timeout_w) begin
               grant_d = '0;
               valid_d = 1'b0;
               hold_d  = '0;
               ptr_d   = gid_q + 1'b1;
               tmo_d   = ~release_w;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            grant_d = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   assign grant       = grant_q;
   assign grant_id    = gid_q;
   assign grant_valid = valid_q;
   assign timeout_err = tmo_q;
   assign dbg_state_o = state_q;
   assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed testbench for rr_arbiter8: reset, basic grant, fairness rotation,
// wrap-around, timeout, release/timeout coincidence and async reset.
module tb_rr_arbiter8;

   logic       clk;
   logic       resetn;
   logic [7:0] req;
   logic       done;
   logic [7:0] grant;
   logic [2:0] grant_id;
   logic       grant_valid;
   logic       timeout_err;
   logic       dbg_state;
   logic [2:0] dbg_ptr;

   int n_checks = 0;
   int n_errors = 0;
   logic [2:0] exp_q[$];

   rr_arbiter8 dut (
      .clk         (clk),
      .resetn      (resetn),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_id    (grant_id),
      .grant_valid (grant_valid),
      .timeout_err (timeout_err),
      .dbg_state_o (dbg_state),
      .dbg_ptr_o   (dbg_ptr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_grant(input string tag, input logic [2:0] id);
      logic [7:0] oh;
      oh = 8'h01 << id;
      check({tag, "_grant"}, grant, oh);
      check({tag, "_id"}, grant_id, id);
      check({tag, "_valid"}, grant_valid, 1);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      tick(2);
      resetn = 1'b1;
   endtask

   initial begin
      logic [2:0] exp_id;
      resetn = 1'b0;
      req    = 8'h00;
      done   = 1'b0;
      tick(3);
      check("rst_grant", grant, 0);
      check("rst_id", grant_id, 0);
      check("rst_valid", grant_valid, 0);
      check("rst_tmo", timeout_err, 0);
      check("rst_state", dbg_state, 0);
      check("rst_ptr", dbg_ptr, 0);
      resetn = 1'b1;

      // Basic grant and done-release
      req = 8'b0000_0100;
      tick();
      check_grant("t1", 3'd2);
      check("t1_state", dbg_state, 1);
      done = 1'b1;
      tick();
      check("t1_rel_grant", grant, 0);
      check("t1_rel_valid", grant_valid, 0);
      check("t1_rel_ptr", dbg_ptr, 3);
      check("t1_rel_id_kept", grant_id, 2);
      done = 1'b0;
      req  = 8'h00;
      tick();

      // Fairness with all requesting, done on every third busy cycle
      do_reset();
      for (int k = 0; k < 9; k++) exp_q.push_back(3'(k % 8));
      req = 8'hFF;
      while (exp_q.size() > 0) begin
         exp_id = exp_q.pop_front();
         tick();
         check_grant("fair", exp_id);
         tick(2);
         check("fair_hold", grant_id, exp_id);
         done = 1'b1;
         tick();
         done = 1'b0;
         check("fair_gap", grant_valid, 0);
      end
      req = 8'h00;
      tick();
      check("fair_ptr", dbg_ptr, 1);

      // Wrap 7 -> 0
      req = 8'h40;
      tick();
      check_grant("wrap6", 3'd6);
      done = 1'b1;
      tick();
      check("wrap_ptr7", dbg_ptr, 7);
      done = 1'b0;
      req  = 8'b1000_0001;
      tick();
      check_grant("wrap7", 3'd7);
      done = 1'b1;
      tick();
      check("wrap_ptr0", dbg_ptr, 0);
      done = 1'b0;
      tick();
      check_grant("wrap0", 3'd0);
      done = 1'b1;
      tick();
      done = 1'b0;
      req  = 8'h00;
      tick();
      check("wrap_ptr1", dbg_ptr, 1);

      // Timeout after 16 held cycles
      req = 8'h10;
      tick();
      check_grant("to", 3'd4);
      for (int c = 1; c < 16; c++) begin
         tick();
         check("to_hold_valid", grant_valid, 1);
         check("to_hold_tmo", timeout_err, 0);
      end
      tick();
      check("to_rel_valid", grant_valid, 0);
      check("to_rel_grant", grant, 0);
      check("to_pulse", timeout_err, 1);
      check("to_ptr", dbg_ptr, 5);
      req = 8'h00;
      tick();
      check("to_pulse_end", timeout_err, 0);
      check("to_idle_valid", grant_valid, 0);

      // Done coinciding with the last hold cycle
      req = 8'h10;
      tick();
      check_grant("co", 3'd4);
      tick(15);
      check("co_still_held", grant_valid, 1);
      done = 1'b1;
      tick();
      check("co_rel_valid", grant_valid, 0);
      check("co_no_tmo", timeout_err, 0);
      done = 1'b0;
      req  = 8'h00;
      tick();
      check("co_no_tmo_late", timeout_err, 0);

      // Owner drops its request mid-busy
      req = 8'h08;
      tick();
      check_grant("drop", 3'd3);
      tick();
      req = 8'h00;
      tick();
      check("drop_valid", grant_valid, 0);
      check("drop_ptr", dbg_ptr, 4);
      check("drop_tmo", timeout_err, 0);

      // Asynchronous reset while busy
      req = 8'h10;
      tick();
      check_grant("ar", 3'd4);
      tick();
      #2 resetn = 1'b0;
      #1;
      check("ar_grant", grant, 0);
      check("ar_valid", grant_valid, 0);
      check("ar_id", grant_id, 0);
      check("ar_ptr", dbg_ptr, 0);
      check("ar_state", dbg_state, 0);
      tick();
      check("ar_tmo", timeout_err, 0);
      req    = 8'h00;
      resetn = 1'b1;
      tick();
      req = 8'h30;
      tick();
      check_grant("ar_after", 3'd4);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
